// File: rtl/riscv_multicycle_controller.sv
// Main FSM for the shared-ALU / shared-memory multi-cycle RV32I datapath.
// Optional `MEM_WAIT_EN adds a mem_ready handshake that stalls the memory states.
module riscv_multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       ALUResult_sign,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR  = 4'd6,  S_ALUWB   = 4'd7,
    S_EXECI    = 4'd8,  S_JAL     = 4'd9,  S_JALR   = 4'd10, S_JALRWB  = 4'd11,
    S_BRANCH   = 4'd12, S_LUI     = 4'd13, S_HALT   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t st, nxt;
  logic   set_illegal, mem_rdy;
  logic   pc_we, mem_we, ir_we, reg_we;
  logic   unused_func7;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign unused_func7 = ^{func7[6], func7[4:0]};

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_decode = sub_en ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  // Signed compares come from the subtraction sign alone; overflow is not corrected.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = !z;
      3'b100:  branch_taken = s;
      3'b101:  branch_taken = !s;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      st <= nxt;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    nxt         = st;
    set_illegal = 1'b0;
    pc_we       = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ImmSrc      = 3'b000;
    ALUControl  = 3'b000;
    case (st)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_rdy) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form OldPC+imm so branch/jal targets sit in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_JAL:       nxt = S_JAL;
          OP_JALR:      nxt = S_JALR;
          OP_BR:        nxt = S_BRANCH;
          OP_LUI:       nxt = S_LUI;
          default: begin
            set_illegal = 1'b1;
            nxt         = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
        nxt     = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (mem_rdy) nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(func3, func7[5]);
        nxt        = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(func3, 1'b0);
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        nxt    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        nxt     = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_we     = 1'b1;
        nxt       = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        reg_we    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_we      = branch_taken(func3, Zero, ALUResult_sign);
        nxt        = S_FETCH;
      end
      S_LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        reg_we    = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

  // Architectural write enables are masked for the whole time reset is held.
  assign PCWrite  = pc_we  & rst;
  assign IRWrite  = ir_we  & rst;
  assign RegWrite = reg_we & rst;
  assign MemWrite = mem_we & rst;
  assign state    = st;

endmodule
